// File: rtl/cache_mem_arbiter.sv
// Two-core icache/dcache arbiter onto a single RAM port, dcache priority, round-robin per class.
// Define ARB_STATS_EN to add per-requester 32-bit grant counters (dgrants/igrants).
module cache_mem_arbiter (
    input  logic        CLK,
    input  logic        rst,
    input  logic [1:0]  iREN,
    input  logic [31:0] iaddr [2],
    output logic [1:0]  iwait,
    output logic [31:0] iload [2],
    input  logic [1:0]  dREN,
    input  logic [1:0]  dWEN,
    input  logic [31:0] daddr [2],
    input  logic [31:0] dstore [2],
    output logic [1:0]  dwait,
    output logic [31:0] dload [2],
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramwait
`ifdef ARB_STATS_EN
    ,
    output logic [31:0] dgrants [2],
    output logic [31:0] igrants [2]
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     r_state;
    logic [1:0] r_owner;
    logic       r_drr;
    logic       r_irr;

    logic [1:0] w_dact;
    logic [1:0] w_iact;
    logic       w_any;
    logic [1:0] w_sel;
    logic       w_own_act;
    logic       w_drive;

    assign w_dact = dREN | dWEN;
    assign w_iact = iREN;
    assign w_any  = (|w_dact) | (|w_iact);

    // owner encoding: bit1 = dcache, bit0 = core
    always_comb begin
        w_sel = 2'd0;
        if (|w_dact) begin
            w_sel = {1'b1, (&w_dact) ? r_drr : w_dact[1]};
        end else begin
            w_sel = {1'b0, (&w_iact) ? r_irr : w_iact[1]};
        end
    end

    assign w_own_act = r_owner[1] ? w_dact[r_owner[0]] : w_iact[r_owner[0]];
    assign w_drive   = (r_state == BUSY) && w_own_act && !rst;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= 2'd0;
            r_drr   <= 1'b0;
            r_irr   <= 1'b0;
`ifdef ARB_STATS_EN
            dgrants[0] <= 32'd0;
            dgrants[1] <= 32'd0;
            igrants[0] <= 32'd0;
            igrants[1] <= 32'd0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state <= BUSY;
                        r_owner <= w_sel;
`ifdef ARB_STATS_EN
                        if (w_sel[1])
                            dgrants[w_sel[0]] <= dgrants[w_sel[0]] + 32'd1;
                        else
                            igrants[w_sel[0]] <= igrants[w_sel[0]] + 32'd1;
`endif
                    end
                end
                BUSY: begin
                    if (!w_own_act) begin
                        r_state <= IDLE;
                        if (r_owner[1])
                            r_drr <= ~r_owner[0];
                        else
                            r_irr <= ~r_owner[0];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        iwait    = 2'b11;
        dwait    = 2'b11;
        iload[0] = 32'd0;
        iload[1] = 32'd0;
        dload[0] = 32'd0;
        dload[1] = 32'd0;
        if (w_drive) begin
            if (r_owner[1]) begin
                // simultaneous REN+WEN is treated as a write
                ramWEN              = dWEN[r_owner[0]];
                ramREN              = dREN[r_owner[0]] & ~dWEN[r_owner[0]];
                ramaddr             = daddr[r_owner[0]];
                ramstore            = dstore[r_owner[0]];
                dwait[r_owner[0]]   = ramwait;
                dload[r_owner[0]]   = ramload;
            end else begin
                ramREN              = 1'b1;
                ramaddr             = iaddr[r_owner[0]];
                iwait[r_owner[0]]   = ramwait;
                iload[r_owner[0]]   = ramload;
            end
        end
    end

endmodule
